// File: rtl/updown_sweep_pkg.sv
// Shared types for the up/down sweep controller: FSM state encoding and direction constants.
// The dwell states exist only when SWEEP_DWELL_EN is defined.
package updown_sweep_pkg;

    typedef enum logic [2:0] {
        IDLE     = 3'd0,
        UP       = 3'd1,
        DOWN     = 3'd2,
        DONE_P   = 3'd3
`ifdef SWEEP_DWELL_EN
        ,
        DWELL_HI = 3'd4,
        DWELL_LO = 3'd5
`endif
    } sweep_state_e;

    localparam logic DIR_UP   = 1'b1;
    localparam logic DIR_DOWN = 1'b0;

endpackage

// File: rtl/updown_counter_core.sv
// Loadable up/down counter stepping by one; load takes priority over the enabled step.
module updown_counter_core
    import updown_sweep_pkg::*;
#(
    parameter int unsigned WIDTH = 3
) (
    input  logic             clk_i,
    input  logic             rst_ni,
    input  logic             load_i,
    input  logic [WIDTH-1:0] load_val_i,
    input  logic             en_i,
    input  logic             up_down_i,
    output logic [WIDTH-1:0] count_o
);

    logic [WIDTH-1:0] count_q;
    logic [WIDTH-1:0] count_d;

    always_comb begin
        count_d = count_q;
        if (load_i) begin
            count_d = load_val_i;
        end else if (en_i) begin
            count_d = (up_down_i == DIR_UP) ? count_q + WIDTH'(1) : count_q - WIDTH'(1);
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    assign count_o = count_q;

endmodule

// File: rtl/updown_sweep_ctrl.sv
// Triangle-sweep sequencer driving updown_counter_core between latched bounds.
// Optional turnaround dwell is built only when SWEEP_DWELL_EN is defined.
module updown_sweep_ctrl
    import updown_sweep_pkg::*;
#(
    parameter int unsigned WIDTH   = 3,
    parameter int unsigned CYC_W   = 4,
    parameter int unsigned DWELL_W = 4
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               start,
    input  logic               abort,
    input  logic [WIDTH-1:0]   lo_bound,
    input  logic [WIDTH-1:0]   hi_bound,
    input  logic [CYC_W-1:0]   num_cycles,
    input  logic [DWELL_W-1:0] dwell,
    output logic [WIDTH-1:0]   count,
    output logic               up_down,
    output logic               busy,
    output logic               done,
    output logic               cfg_err
);

    sweep_state_e     state_q;
    logic [WIDTH-1:0] lo_q;
    logic [WIDTH-1:0] hi_q;
    logic [CYC_W-1:0] ncyc_q;
    logic [CYC_W-1:0] cyc_q;
    logic [CYC_W-1:0] cyc_d;
    logic             busy_q;
    logic             done_q;
    logic             cfg_err_q;
    logic             up_down_q;

    logic             load;
    logic             step_en;
    logic             step_up;
    logic             cfg_ok;
    logic             at_top;
    logic             at_last;
    logic             last_cycle;

`ifdef SWEEP_DWELL_EN
    logic [DWELL_W-1:0] dwell_q;
    logic [DWELL_W-1:0] dcnt_q;
    logic               dwell_end;

    assign dwell_end = (dcnt_q == dwell_q - DWELL_W'(1));
`else
    logic unused_dwell;

    assign unused_dwell = ^dwell;
`endif

    assign cfg_ok     = (lo_bound < hi_bound);
    assign at_top     = (count == hi_q - WIDTH'(1));
    assign at_last    = (count == lo_q + WIDTH'(1));
    assign cyc_d      = cyc_q + CYC_W'(1);
    assign last_cycle = (ncyc_q != '0) && (cyc_d == ncyc_q);

    always_comb begin
        load    = 1'b0;
        step_en = 1'b0;
        step_up = DIR_UP;
        case (state_q)
            IDLE: load = start && cfg_ok;
            UP: begin
                step_en = !abort;
                step_up = DIR_UP;
            end
            DOWN: begin
                step_en = !abort && (count != lo_q);
                step_up = DIR_DOWN;
            end
            default: ;
        endcase
    end

    updown_counter_core #(
        .WIDTH(WIDTH)
    ) u_core (
        .clk_i      (clk),
        .rst_ni     (reset),
        .load_i     (load),
        .load_val_i (lo_bound),
        .en_i       (step_en),
        .up_down_i  (step_up),
        .count_o    (count)
    );

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q   <= IDLE;
            lo_q      <= '0;
            hi_q      <= '0;
            ncyc_q    <= '0;
            cyc_q     <= '0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
            cfg_err_q <= 1'b0;
            up_down_q <= DIR_UP;
`ifdef SWEEP_DWELL_EN
            dwell_q   <= '0;
            dcnt_q    <= '0;
`endif
        end else begin
            done_q    <= 1'b0;
            cfg_err_q <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (start) begin
                        if (cfg_ok) begin
                            lo_q      <= lo_bound;
                            hi_q      <= hi_bound;
                            ncyc_q    <= num_cycles;
                            cyc_q     <= '0;
                            busy_q    <= 1'b1;
                            up_down_q <= DIR_UP;
                            state_q   <= UP;
`ifdef SWEEP_DWELL_EN
                            dwell_q   <= dwell;
                            dcnt_q    <= '0;
`endif
                        end else begin
                            cfg_err_q <= 1'b1;
                        end
                    end
                end
                UP: begin
                    if (abort) begin
                        state_q <= IDLE;
                        busy_q  <= 1'b0;
                    end else if (at_top) begin
`ifdef SWEEP_DWELL_EN
                        if (dwell_q != '0) begin
                            state_q <= DWELL_HI;
                        end else begin
                            state_q   <= DOWN;
                            up_down_q <= DIR_DOWN;
                        end
`else
                        state_q   <= DOWN;
                        up_down_q <= DIR_DOWN;
`endif
                    end
                end
                DOWN: begin
                    if (abort) begin
                        state_q <= IDLE;
                        busy_q  <= 1'b0;
                    end else if (count == lo_q) begin
                        // Final cycle stays in DOWN for the cycle showing lo, so lo is seen busy before done.
                        state_q <= DONE_P;
                        busy_q  <= 1'b0;
                        done_q  <= 1'b1;
                    end else if (at_last) begin
                        cyc_q <= cyc_d;
                        if (!last_cycle) begin
`ifdef SWEEP_DWELL_EN
                            if (dwell_q != '0) begin
                                state_q <= DWELL_LO;
                            end else begin
                                state_q   <= UP;
                                up_down_q <= DIR_UP;
                            end
`else
                            state_q   <= UP;
                            up_down_q <= DIR_UP;
`endif
                        end
                    end
                end
`ifdef SWEEP_DWELL_EN
                DWELL_HI: begin
                    if (abort) begin
                        state_q <= IDLE;
                        busy_q  <= 1'b0;
                        dcnt_q  <= '0;
                    end else if (dwell_end) begin
                        dcnt_q    <= '0;
                        state_q   <= DOWN;
                        up_down_q <= DIR_DOWN;
                    end else begin
                        dcnt_q <= dcnt_q + DWELL_W'(1);
                    end
                end
                DWELL_LO: begin
                    if (abort) begin
                        state_q <= IDLE;
                        busy_q  <= 1'b0;
                        dcnt_q  <= '0;
                    end else if (dwell_end) begin
                        dcnt_q    <= '0;
                        state_q   <= UP;
                        up_down_q <= DIR_UP;
                    end else begin
                        dcnt_q <= dcnt_q + DWELL_W'(1);
                    end
                end
`endif
                DONE_P:  state_q <= IDLE;
                default: state_q <= IDLE;
            endcase
        end
    end

    assign up_down = up_down_q;
    assign busy    = busy_q;
    assign done    = done_q;
    assign cfg_err = cfg_err_q;

endmodule
